// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: byte-lane data memory with an integrated load/store unit.
// Requests are accepted on a valid/ready channel. Stores are steered onto
// byte lanes and commit at the accept edge. Loads are read at the accept
// edge, realigned and extended, and returned one cycle later.
// Misaligned, unsupported-size and out-of-range accesses return a fault.
// The array is optionally swept to zero after reset.
module dmem_lane_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              init_busy
);

  localparam int NLANES = DATA_W / 8;
  localparam int LB     = $clog2(NLANES);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int IDX_LO = ADDR_W + LB;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_W-1:0]   idx_s;
  logic [LB-1:0]       off_s;
  logic [4:0]          off_ext_s;
  logic [3:0]          nbytes_s;
  logic [6:0]          nbits_s;
  logic                size_bad_s, align_bad_s, range_bad_s, fault_s;
  logic                accept_s, store_s;
  logic [NLANES-1:0]   be_s;
  logic [NLANES-1:0]   lane_we_s;
  logic [ADDR_W-1:0]   wr_idx_s;
  logic [DATA_W-1:0]   wdata_shift_s, wr_data_s;
  logic [DATA_W-1:0]   rd_word_s, shifted_s, mask_s, ext_s;
  logic                msb_s, fill_s;

  // Address decode: word index, byte offset and access length.
  assign idx_s     = req_addr[IDX_LO-1:LB];
  assign off_s     = req_addr[LB-1:0];
  assign off_ext_s = 5'(off_s);
  assign nbytes_s  = 4'd1 << req_size;
  assign nbits_s   = {nbytes_s, 3'b000};
  assign req_ready = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);
  assign accept_s  = req_valid & req_ready;
  assign store_s   = accept_s & req_we & ~fault_s;

  // Fault classification: dword on a 32-bit array, misalignment, high address bits.
  always_comb begin
    size_bad_s  = 1'b0;
    align_bad_s = 1'b0;
    range_bad_s = 1'b0;
    if ((req_size == 2'd3) && (DATA_W == 32)) begin
      size_bad_s = 1'b1;
    end else begin
      size_bad_s = 1'b0;
    end
    align_bad_s = ((off_ext_s & (5'(nbytes_s) - 5'd1)) != 5'd0);
    range_bad_s = ((req_addr >> IDX_LO) != 32'd0);
    fault_s     = size_bad_s | align_bad_s | range_bad_s;
  end

  // Lane enables cover lanes off .. off+nbytes-1; store data is shifted up to match.
  always_comb begin
    be_s = {NLANES{1'b0}};
    for (int i = 0; i < NLANES; i++) begin
      be_s[i] = (5'(i) >= off_ext_s) && (5'(i) < (off_ext_s + 5'(nbytes_s)));
    end
    wdata_shift_s = req_wdata << {off_s, 3'b000};
  end

  // Write port mux: sweep writes zero to every lane, run mode writes enabled store lanes.
  always_comb begin
    lane_we_s = {NLANES{1'b0}};
    wr_idx_s  = idx_s;
    wr_data_s = wdata_shift_s;
    if (reset) begin
      lane_we_s = {NLANES{1'b0}};
    end else if (state_q == ST_INIT) begin
      lane_we_s = {NLANES{1'b1}};
      wr_idx_s  = cnt_q;
      wr_data_s = {DATA_W{1'b0}};
    end else if (store_s) begin
      lane_we_s = be_s;
    end else begin
      lane_we_s = {NLANES{1'b0}};
    end
  end

  // One independent 8-bit array per lane; writes are never reset, so contents survive reset.
  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Per-lane synchronous write.
    always_ff @(posedge clk) begin
      if (lane_we_s[g]) begin
        mem[wr_idx_s] <= wr_data_s[g*8 +: 8];
      end
    end

    assign rd_word_s[g*8 +: 8] = mem[idx_s];
  end

  // Load realignment: shift the field down, then sign- or zero-fill above it.
  always_comb begin
    shifted_s = rd_word_s >> {off_s, 3'b000};
    mask_s    = ~({DATA_W{1'b1}} << nbits_s);
    msb_s     = 1'b0;
    case (req_size)
      2'd0:    msb_s = shifted_s[7];
      2'd1:    msb_s = shifted_s[15];
      2'd2:    msb_s = shifted_s[31];
      default: msb_s = shifted_s[DATA_W-1];
    endcase
    fill_s = req_signed & msb_s;
    ext_s  = (shifted_s & mask_s) | (~mask_s & {DATA_W{fill_s}});
  end

  // Sweep/run sequencing and response capture; response fields hold between requests.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = accept_s;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
    if (accept_s) begin
      rsp_fault_d = fault_s;
      if (fault_s || req_we) begin
        rsp_rdata_d = {DATA_W{1'b0}};
      end else begin
        rsp_rdata_d = ext_s;
      end
    end else begin
      rsp_fault_d = rsp_fault_q;
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // State, sweep counter and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      cnt_q       <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed testbench for dmem_lane_ctrl: three instances (32-bit with clear,
// 64-bit with clear, 32-bit without clear) share one request channel.
module tb_dmem_lane_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        rdy32, r32_valid, r32_fault, busy32;
  logic [31:0] r32_rdata;
  logic        rdy64, r64_valid, r64_fault, busy64;
  logic [63:0] r64_rdata;
  logic        rdync, rnc_valid, rnc_fault, busync;
  logic [31:0] rnc_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.DATA_W(32), .ADDR_W(4), .INIT_CLEAR(1'b1)) u_dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy32),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(r32_valid),
    .rsp_rdata(r32_rdata), .rsp_fault(r32_fault), .init_busy(busy32));

  dmem_lane_ctrl #(.DATA_W(64), .ADDR_W(4), .INIT_CLEAR(1'b1)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy64),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r64_valid),
    .rsp_rdata(r64_rdata), .rsp_fault(r64_fault), .init_busy(busy64));

  dmem_lane_ctrl #(.DATA_W(32), .ADDR_W(4), .INIT_CLEAR(1'b0)) u_dutnc (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdync),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .rsp_valid(rnc_valid),
    .rsp_rdata(rnc_rdata), .rsp_fault(rnc_fault), .init_busy(busync));

  // Present one request for one clock edge; returns 1 time unit after that edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Check the 16-cycle sweep window of the 32-bit instance, then ready.
  task automatic check_sweep(input string nm);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (rdy32 !== 1'b0 || busy32 !== 1'b1 || r32_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busy[%0d]: got rdy/busy/v=%b/%b/%b, expected 0/1/0", nm, k, rdy32, busy32, r32_valid);
      end
      idle();
    end
    vectors++;
    if (rdy32 !== 1'b1 || busy32 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_ready: got rdy/busy=%b/%b, expected 1/0", nm, rdy32, busy32);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata, rdy32, busy32} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset32: got v/f/d/rdy/busy=%b/%b/%h/%b/%b, expected 0/0/00000000/0/1", r32_valid, r32_fault, r32_rdata, rdy32, busy32);
    end
    vectors++;
    if ({r64_valid, r64_fault, r64_rdata, rdy64, busy64} !== {1'b0, 1'b0, 64'h0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset64: got v/f/d/rdy/busy=%b/%b/%h/%b/%b, expected 0/0/0/0/1", r64_valid, r64_fault, r64_rdata, rdy64, busy64);
    end
    vectors++;
    if ({rnc_valid, rnc_fault, rnc_rdata, rdync, busync} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_noclear: got v/f/d/rdy/busy=%b/%b/%h/%b/%b, expected 0/0/00000000/1/0", rnc_valid, rnc_fault, rnc_rdata, rdync, busync);
    end
  endtask

  task automatic test_init_sweep();
    reset = 1'b0;
    check_sweep("init");
    vectors++;
    if (rdy64 !== 1'b1) begin
      miscompares++;
      $display("FAIL init_ready64: got %b, expected 1", rdy64);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h3C, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL init_ld_3c: got v/f/d=%b/%b/%h, expected 1/0/00000000", r32_valid, r32_fault, r32_rdata);
    end
  endtask

  task automatic test_load_extend();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 64'hDEADBEEF);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL st_w_rsp: got v/f/d=%b/%b/%h, expected 1/0/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd0, 1'b1, 32'h11, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'hFFFFFFBE}) begin
      miscompares++;
      $display("FAIL ld_b_s: got v/f/d=%b/%b/%h, expected 1/0/ffffffbe", r32_valid, r32_fault, r32_rdata);
    end
    vectors++;
    if (r64_rdata !== 64'hFFFFFFFFFFFFFFBE) begin
      miscompares++;
      $display("FAIL ld_b_s64: got %h, expected ffffffffffffffbe", r64_rdata);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h11, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'h000000BE}) begin
      miscompares++;
      $display("FAIL ld_b_u: got v/f/d=%b/%b/%h, expected 1/0/000000be", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd1, 1'b1, 32'h12, 64'd0);
    vectors++;
    if (r32_rdata !== 32'hFFFFDEAD) begin
      miscompares++;
      $display("FAIL ld_h_s: got %h, expected ffffdead", r32_rdata);
    end
    issue(1'b0, 2'd1, 1'b0, 32'h12, 64'd0);
    vectors++;
    if (r32_rdata !== 32'h0000DEAD) begin
      miscompares++;
      $display("FAIL ld_h_u: got %h, expected 0000dead", r32_rdata);
    end
  endtask

  task automatic test_partial_store();
    issue(1'b1, 2'd0, 1'b0, 32'h13, 64'hFFFFFF5A);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 64'd0);
    vectors++;
    if (r32_rdata !== 32'h5AADBEEF) begin
      miscompares++;
      $display("FAIL st_b_merge: got %h, expected 5aadbeef", r32_rdata);
    end
    issue(1'b1, 2'd1, 1'b0, 32'h10, 64'hABCD1234);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 64'd0);
    vectors++;
    if (r32_rdata !== 32'h5AAD1234) begin
      miscompares++;
      $display("FAIL st_h_merge: got %h, expected 5aad1234", r32_rdata);
    end
  endtask

  task automatic test_faults();
    issue(1'b1, 2'd1, 1'b0, 32'h11, 64'h7777);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_half11: got v/f/d=%b/%b/%h, expected 1/1/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h12, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_word12: got v/f/d=%b/%b/%h, expected 1/1/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b1, 2'd3, 1'b0, 32'h10, 64'hFFFFFFFF);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_size3: got v/f/d=%b/%b/%h, expected 1/1/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h40, 64'hFFFFFFFF);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_range40: got v/f/d=%b/%b/%h, expected 1/1/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h80000010, 64'd0);
    vectors++;
    if ({r32_fault, r32_rdata} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_range_hi: got f/d=%b/%h, expected 1/00000000", r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 64'd0);
    vectors++;
    if ({r32_fault, r32_rdata} !== {1'b0, 32'h5AAD1234}) begin
      miscompares++;
      $display("FAIL flt_mem10: got f/d=%b/%h, expected 0/5aad1234", r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h00, 64'd0);
    vectors++;
    if ({r32_fault, r32_rdata} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL flt_mem00: got f/d=%b/%h, expected 0/00000000", r32_fault, r32_rdata);
    end
  endtask

  task automatic test_dword();
    issue(1'b1, 2'd3, 1'b0, 32'h08, 64'h0123456789ABCDEF);
    vectors++;
    if ({r64_valid, r64_fault, r64_rdata} !== {1'b1, 1'b0, 64'h0}) begin
      miscompares++;
      $display("FAIL st_d_rsp: got v/f/d=%b/%b/%h, expected 1/0/0", r64_valid, r64_fault, r64_rdata);
    end
    issue(1'b0, 2'd2, 1'b1, 32'h0C, 64'd0);
    vectors++;
    if (r64_rdata !== 64'h0000000001234567) begin
      miscompares++;
      $display("FAIL ld_w_s_0c: got %h, expected 0000000001234567", r64_rdata);
    end
    issue(1'b0, 2'd0, 1'b1, 32'h0F, 64'd0);
    vectors++;
    if (r64_rdata !== 64'h0000000000000001) begin
      miscompares++;
      $display("FAIL ld_b_s_0f: got %h, expected 0000000000000001", r64_rdata);
    end
    issue(1'b0, 2'd2, 1'b1, 32'h08, 64'd0);
    vectors++;
    if (r64_rdata !== 64'hFFFFFFFF89ABCDEF) begin
      miscompares++;
      $display("FAIL ld_w_s_08: got %h, expected ffffffff89abcdef", r64_rdata);
    end
    issue(1'b0, 2'd1, 1'b1, 32'h0A, 64'd0);
    vectors++;
    if (r64_rdata !== 64'hFFFFFFFFFFFF89AB) begin
      miscompares++;
      $display("FAIL ld_h_s_0a: got %h, expected ffffffffffff89ab", r64_rdata);
    end
    issue(1'b1, 2'd0, 1'b0, 32'h0D, 64'hFFFFFFFFFFFFFF77);
    issue(1'b0, 2'd3, 1'b0, 32'h08, 64'd0);
    vectors++;
    if ({r64_fault, r64_rdata} !== {1'b0, 64'h0123776789ABCDEF}) begin
      miscompares++;
      $display("FAIL ld_d_merge: got f/d=%b/%h, expected 0/0123776789abcdef", r64_fault, r64_rdata);
    end
    issue(1'b0, 2'd3, 1'b0, 32'h0C, 64'd0);
    vectors++;
    if ({r64_valid, r64_fault, r64_rdata} !== {1'b1, 1'b1, 64'h0}) begin
      miscompares++;
      $display("FAIL flt_d_0c: got v/f/d=%b/%b/%h, expected 1/1/0", r64_valid, r64_fault, r64_rdata);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'd2, 1'b0, 32'h24, 64'hA5A5A5A5);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL b2b_st: got v/f/d=%b/%b/%h, expected 1/0/00000000", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h24, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("FAIL b2b_ld_w: got v/f/d=%b/%b/%h, expected 1/0/a5a5a5a5", r32_valid, r32_fault, r32_rdata);
    end
    issue(1'b0, 2'd0, 1'b1, 32'h24, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'hFFFFFFA5}) begin
      miscompares++;
      $display("FAIL b2b_ld_b: got v/f/d=%b/%b/%h, expected 1/0/ffffffa5", r32_valid, r32_fault, r32_rdata);
    end
    idle();
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b0, 1'b0, 32'hFFFFFFA5}) begin
      miscompares++;
      $display("FAIL b2b_hold: got v/f/d=%b/%b/%h, expected 0/0/ffffffa5", r32_valid, r32_fault, r32_rdata);
    end
  endtask

  task automatic test_reset_midflight();
    issue(1'b1, 2'd2, 1'b0, 32'h20, 64'h11223344);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 64'd0);
    reset = 1'b1;
    #1;
    vectors++;
    if ({r32_valid, r32_rdata, rnc_valid, r64_valid} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_drop: got v32/d32/vnc/v64=%b/%h/%b/%b, expected 0/00000000/0/0", r32_valid, r32_rdata, rnc_valid, r64_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({busy32, rdy32, rdync} !== {1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_state: got busy32/rdy32/rdync=%b/%b/%b, expected 1/0/1", busy32, rdy32, rdync);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h20, 64'd0);
    vectors++;
    if ({rnc_valid, rnc_fault, rnc_rdata, r32_valid} !== {1'b1, 1'b0, 32'h11223344, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_retain: got vnc/fnc/dnc/v32=%b/%b/%h/%b, expected 1/0/11223344/0", rnc_valid, rnc_fault, rnc_rdata, r32_valid);
    end
    repeat (4) idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_sweep("resweep");
    issue(1'b0, 2'd2, 1'b0, 32'h20, 64'd0);
    vectors++;
    if ({r32_valid, r32_fault, r32_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL rst_cleared: got v/f/d=%b/%b/%h, expected 1/0/00000000", r32_valid, r32_fault, r32_rdata);
    end
    vectors++;
    if (rnc_rdata !== 32'h11223344) begin
      miscompares++;
      $display("FAIL rst_retain2: got %h, expected 11223344", rnc_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_load_extend();
    test_partial_store();
    test_faults();
    test_dword();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
Parametrised byte-lane data memory with an integrated load/store unit. It supersedes the fixed 32-bit byte-enabled RAM in the data path.
- Accepts byte/half/word (and dword when 64-bit) accesses over a valid/ready request channel.
- Generates lane enables internally, steers store data onto the correct lanes, and realigns and sign/zero-extends load data.
- Flags misaligned, unsupported-size and out-of-range accesses.
- Optionally sweeps the array to zero after reset.

Parameters:
DATA_W, 32, word width in bits; legal values 32 or 64; NLANES = DATA_W/8, LB = log2(NLANES).
ADDR_W, 11, word-index width; DEPTH = 2**ADDR_W words.
INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests; 0 = ready immediately, contents undefined.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64)
req_signed  input  1  load sign-extends when 1, zero-extends when 0
req_addr  input  32  byte address
req_wdata  input  DATA_W  store data, right-aligned (LSB-justified)
rsp_valid  output  1  one-cycle pulse, one per accepted request
rsp_rdata  output  DATA_W  load result, right-aligned and extended; 0 for stores and faults
rsp_fault  output  1  valid with rsp_valid; access was rejected
init_busy  output  1  clear sweep in progress

Behaviour:
- Reset values and entry state:
  - Async reset forces rsp_valid=0, rsp_rdata=0, rsp_fault=0 and the sweep counter to 0.
  - State after reset is INIT if INIT_CLEAR=1, otherwise RUN.
  - req_ready=0 and init_busy=1 while in INIT.
- FSM:
  - INIT: writes zero to word[cnt] with all lanes enabled, then cnt++. After the write to word DEPTH-1 (cnt wraps), transition to RUN; that final write completes DEPTH cycles after reset release.
  - RUN: req_ready=1 every cycle. There is no backpressure, and the FSM never leaves RUN except on reset.
- Acceptance: a request is accepted on a clk edge where req_valid & req_ready.
- Response timing:
  - rsp_valid rises exactly 1 cycle after acceptance and holds for 1 cycle.
  - Back-to-back requests produce back-to-back responses.
  - rsp_rdata and rsp_fault are registered and hold their value when rsp_valid=0.
- Decode:
  - index = req_addr[ADDR_W+LB-1:LB].
  - off = req_addr[LB-1:0].
  - nbytes = 1 << req_size.
- Fault conditions (any one sets rsp_fault=1):
  - (a) req_size=3 with DATA_W=32.
  - (b) off not a multiple of nbytes.
  - (c) req_addr[31:ADDR_W+LB] nonzero.
  - On fault: no memory write, rsp_rdata=0, rsp_valid still pulses.
- Store:
  - Lane enable be[i] = 1 for off <= i < off+nbytes.
  - Lane i receives byte (i-off) of req_wdata; bytes of req_wdata above nbytes are ignored.
  - Lanes with be=0 are unchanged.
  - Lane 0 is the least-significant byte (little-endian).
- Load:
  - The array is read at the accepted index.
  - Bytes off..off+nbytes-1 are shifted down to bit 0.
  - Bits above 8*nbytes are filled with the MSB of the selected field if req_signed=1, else with 0.
- Hazard: a load to the same word one cycle after a store returns the post-store data, because the write commits at the accept edge of the store.
- Reset mid-operation:
  - Any pending response is dropped (rsp_valid=0).
  - Memory contents are retained.
  - If INIT_CLEAR=1, the sweep restarts from index 0.
- Storage: NLANES independent 8-bit x DEPTH arrays, each with its own write enable.

Test Plan:
1. INIT_CLEAR=1, ADDR_W=4: release reset -> init_busy=1 and req_ready=0 for 16 cycles, then req_ready=1; a word load from 0x3C -> rsp_rdata=0x00000000, rsp_fault=0.
2. Store word 0xDEADBEEF @0x10, then byte loads @0x11 signed and unsigned -> 0xFFFFFFBE and 0x000000BE; half load @0x12 signed -> 0xFFFFDEAD.
3. Store byte 0x5A @0x13 over 0xDEADBEEF, then word load @0x10 -> 0x5AADBEEF (other lanes untouched); store half 0x1234 @0x10 -> word reads 0x5AAD1234.
4. Faults, all with rsp_fault=1, rsp_rdata=0 and memory unchanged:
   - half @0x11.
   - word @0x12.
   - size=3 with DATA_W=32.
   - address 0x0000_0040 with ADDR_W=4.
5. DATA_W=64: store dword 0x0123456789ABCDEF @0x8, then word load @0xC signed -> 0x0000000001234567; byte @0xF signed -> 0x0000000000000001.
6. Reset asserted for 1 cycle mid-sweep and again with a load in flight -> rsp_valid stays 0, sweep restarts at index 0; data stored before the reset is read as 0 after a re-sweep, and is retained when INIT_CLEAR=0.
